// File: rtl/cl_ocl_regfile.sv
// cl_ocl_regfile: AXI-Lite slave register file on the OCL path.
// NUM_REGS 32-bit registers with read-only and byte-swap attributes per slot,
// byte-strobe writes, independent AW/W buffering, AXI error responses and
// per-register write pulses.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid && ready are both high; a source holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module cl_ocl_regfile #(
  parameter int                      NUM_REGS     = 8,
  parameter logic [31:0]             BASE_ADDR    = 32'h0000_0500,
  parameter logic [NUM_REGS-1:0]     RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]     BSWAP_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0]  RESET_VAL    = '0,
  parameter logic [31:0]             UNIMPL_VALUE = 32'hDEAF_DEAD
) (
  input  logic                      clk_main_a0,
  input  logic                      rst_main_n_sync,
  input  logic                      awvalid,
  input  logic [31:0]               awaddr,
  output logic                      awready,
  input  logic                      wvalid,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  output logic                      wready,
  output logic                      bvalid,
  output logic [1:0]                bresp,
  input  logic                      bready,
  input  logic                      arvalid,
  input  logic [31:0]               araddr,
  output logic                      arready,
  output logic                      rvalid,
  output logic [31:0]               rdata,
  output logic [1:0]                rresp,
  input  logic                      rready,
  output logic [NUM_REGS*32-1:0]    reg_q,
  input  logic [NUM_REGS*32-1:0]    status_in,
  output logic [NUM_REGS-1:0]       wr_pulse
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic          mapped;
    logic [IW-1:0] idx;
  } dec_t;

  // Offset below 4*NUM_REGS is the same test as offset[31:2] < NUM_REGS;
  // the low address bits never affect the slot chosen.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] off;
    dec_t        d;
    off      = addr - BASE_ADDR;
    d.mapped = (addr >= BASE_ADDR) && (off < 32'(NUM_REGS * 4));
    d.idx    = off[IW+1:2];
    return d;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic [31:0] regs [NUM_REGS];

  logic        aw_held;
  logic [31:0] aw_addr_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  dec_t        wr_dec;
  dec_t        rd_dec;
  logic        commit;
  logic        wr_ok;
  logic [31:0] rd_raw;
  logic [31:0] rd_val;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid;

  // A new commit waits for the previous response to be taken.
  assign wr_dec = decode(aw_addr_q);
  assign commit = aw_held && w_held && !bvalid;
  assign wr_ok  = commit && wr_dec.mapped && !RO_MASK[wr_dec.idx];

  // Read source selection for the address currently on the AR channel.
  always_comb begin
    rd_dec = decode(araddr);
    rd_raw = RO_MASK[rd_dec.idx] ? status_in[rd_dec.idx*32 +: 32] : regs[rd_dec.idx];
    rd_val = UNIMPL_VALUE;
    if (rd_dec.mapped) begin
      rd_val = BSWAP_MASK[rd_dec.idx] ? bswap(rd_raw) : rd_raw;
    end
  end

  // One-cycle strobe on the slot written in the commit cycle.
  always_comb begin
    wr_pulse = '0;
    if (wr_ok) wr_pulse[wr_dec.idx] = 1'b1;
  end

  // Register storage with byte-strobe update; read-only slots stay at zero.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
      end
    end else if (wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (w_strb_q[k]) regs[wr_dec.idx][8*k +: 8] <= w_data_q[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[32*g +: 32] = RO_MASK[g] ? 32'h0 : regs[g];
  end

  // Write path: one-deep AW and W buffers, commit and B response.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      aw_held   <= 1'b0;
      aw_addr_q <= 32'h0;
      w_held    <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        if (!wr_dec.mapped)             bresp <= RESP_DECERR;
        else if (RO_MASK[wr_dec.idx])   bresp <= RESP_SLVERR;
        else                            bresp <= RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Read path: decode at the AR handshake, hold R until taken, then clear.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= rd_dec.mapped ? RESP_OKAY : RESP_DECERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
      rresp  <= RESP_OKAY;
    end
  end

endmodule

// File: doc/cl_ocl_regfile.md
Name: cl_ocl_regfile

Overview:
- Parametrised AXI-Lite slave register file on the OCL (AppPF BAR0) path, downstream of the OCL register slice.
- Replaces single-register, hand-decoded slaves with NUM_REGS 32-bit registers.
- Adds per-register read-only and byte-swap attributes, byte-strobe writes, independent AW/W acceptance, AXI error responses and per-register write pulses.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (1..64)
- BASE_ADDR, 32'h0000_0500, byte address of register 0; register i sits at BASE_ADDR + 4*i
- RO_MASK, all zeros (NUM_REGS bits), bit i = 1 makes register i read-only; it reads from status_in
- BSWAP_MASK, all zeros (NUM_REGS bits), bit i = 1 returns register i byte-swapped on read ({[7:0],[15:8],[23:16],[31:24]})
- RESET_VAL, all zeros (NUM_REGS*32 bits), reset value of each RW register, register i in bits [32*i+31:32*i]
- UNIMPL_VALUE, 32'hDEAF_DEAD, read data returned for an out-of-range address

Ports:
- clk_main_a0  in  1  clock
- rst_main_n_sync  in  1  synchronous active-low reset
- awvalid / awaddr / awready  in/in/out  1/32/1  write address channel
- wvalid / wdata / wstrb / wready  in/in/in/out  1/32/4/1  write data channel
- bvalid / bresp / bready  out/out/in  1/2/1  write response channel
- arvalid / araddr / arready  in/in/out  1/32/1  read address channel
- rvalid / rdata / rresp / rready  out/out/out/in  1/32/2/1  read data channel
- reg_q  out  NUM_REGS*32  current RW register contents; RO slots drive 0
- status_in  in  NUM_REGS*32  read-only sources, sampled at read decode; ignored for RW slots
- wr_pulse  out  NUM_REGS  one-cycle strobe when register i is written (RW register with OKAY response only)

Behaviour:
- Reset (rst_main_n_sync=0 at posedge):
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0.
  - reg_q = RESET_VAL; all internal buffers are cleared.
  - Reset mid-transaction drops the transaction with no response and no register update.
- Decode:
  - offset = addr - BASE_ADDR; addr[1:0] is ignored; idx = offset[31:2].
  - In range when addr >= BASE_ADDR and idx < NUM_REGS; otherwise the access is unmapped.
- Write address and data are accepted independently:
  - awready = !aw_held; wready = !w_held.
  - An AW handshake latches awaddr and sets aw_held; a W handshake latches wdata/wstrb and sets w_held. Either may arrive first, or both in the same cycle.
- Write commit happens in the cycle where aw_held && w_held && !bvalid.
  - Mapped RW: each byte k with wstrb[k]=1 updates reg[idx][8k+7:8k]. wr_pulse[idx]=1 for exactly that cycle, even if wstrb=0. bresp=OKAY(00).
  - Mapped RO: no update, no pulse, bresp=SLVERR(10).
  - Unmapped: no update, no pulse, bresp=DECERR(11).
  - In all cases bvalid=1 the cycle after commit, and aw_held/w_held clear at commit, so awready and wready return high the cycle after commit.
  - bvalid holds with bresp stable until bready. A new commit cannot occur while bvalid=1, but AW and W may still be buffered (one deep each).
  - Write latency: 1 cycle from the later of the AW/W handshakes to bvalid.
- Read:
  - arready = !rvalid. The AR handshake decodes in that same cycle; rvalid=1 on the next cycle.
  - rdata values:
    - Mapped RW: register value, byte-swapped when BSWAP_MASK[idx].
    - Mapped RO: status_in slot as sampled in the handshake cycle, byte-swap applied.
    - Unmapped: UNIMPL_VALUE.
  - rresp: OKAY for mapped, DECERR for unmapped.
  - rvalid and rdata hold stable until rready; on the rvalid&&rready cycle rvalid=0 and rdata=0.
  - Read latency: 1 cycle; at most one read outstanding.
- Simultaneous events:
  - A read and a write commit to the same register in the same cycle: the read returns the pre-write value.
  - The read and write paths are fully independent; neither stalls the other.
- Reads have no side effects.

Test Plan:
- Reset, then read reg 2 (addr 0x508) with RESET_VAL[2]=32'h1234_5678 and BSWAP_MASK[2]=1 -> rdata=32'h7856_3412, rresp=00, rvalid one cycle after the AR handshake.
- W before AW: W 32'hAABB_CCDD with wstrb=4'b0101, then AW 0x500 two cycles later, starting from reg0=0 -> bvalid one cycle after the AW handshake, bresp=00, wr_pulse[0] single cycle, reg0=32'h00BB_00DD.
- Write to RO reg 3 (RO_MASK[3]=1), then read 0x50C with status_in[3]=32'hCAFE_0001 -> bresp=10, reg_q unchanged, no wr_pulse, rdata=32'hCAFE_0001.
- Read 0x400 and write 0x520 (NUM_REGS=8) -> rresp=11 with rdata=32'hDEAF_DEAD; bresp=11; no register change.
- Hold bready=0 for 5 cycles after a write, then issue a second AW+W -> both accepted once each (buffered), awready/wready low thereafter, second bvalid one cycle after the first B handshake; same-cycle AR of the written register returns its old value.
- Assert reset with AW held and rvalid pending -> next cycle rvalid=0, bvalid=0, arready=awready=wready=1, reg_q=RESET_VAL.
